free_station_display: RTL and testbench



---
 rtl/free_station_display.sv | 157 +++++++++++++++
 tb/tb_free_station_display.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/free_station_display.sv
// Lab occupancy display: per-station sync/debounce, free-station count, 2-digit muxed 7-seg.
// Optional ZERO_BLINK_EN: blink the "0" on alternate UNITS+TENS periods while every station is busy.

module fsd_lane #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync   <= '0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == stable) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        stable <= ~stable;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module free_station_display #(
  parameter int N_COMPS         = 5,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REFRESH_CYCLES  = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_COMPS-1:0] comps,
  output logic [6:0]         free_cnt,
  output logic [6:0]         seg,
  output logic [1:0]         an,
  output logic               all_busy,
  output logic               cnt_changed
);
  localparam int RW = $clog2(REFRESH_CYCLES);

  typedef enum logic {UNITS, TENS} state_t;

  logic [N_COMPS-1:0] stable;
  logic [6:0]         on_cnt, free_nxt;
  logic [3:0]         tens, units;
  state_t             state, state_nxt;
  logic [RW-1:0]      rcnt;
  logic               rwrap;
  logic [6:0]         seg_d;
  logic [1:0]         an_d;

  fsd_lane #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lane [N_COMPS-1:0] (
    .clk    (clk),
    .rst    (rst),
    .raw    (comps),
    .stable (stable)
  );

  always_comb begin
    on_cnt = '0;
    for (int i = 0; i < N_COMPS; i++) on_cnt = on_cnt + 7'(stable[i]);
    free_nxt = 7'(N_COMPS) - on_cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      free_cnt    <= 7'(N_COMPS);
      all_busy    <= 1'b0;
      cnt_changed <= 1'b0;
      tens        <= 4'(N_COMPS / 10);
      units       <= 4'(N_COMPS % 10);
    end else begin
      free_cnt    <= free_nxt;
      all_busy    <= (free_nxt == 7'd0);
      cnt_changed <= (free_nxt != free_cnt);
      tens        <= 4'(free_cnt / 7'd10);
      units       <= 4'(free_cnt % 7'd10);
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1111110;
      4'd1:    seg7 = 7'b0110000;
      4'd2:    seg7 = 7'b1101101;
      4'd3:    seg7 = 7'b1111001;
      4'd4:    seg7 = 7'b0110011;
      4'd5:    seg7 = 7'b1011011;
      4'd6:    seg7 = 7'b1011111;
      4'd7:    seg7 = 7'b1110000;
      4'd8:    seg7 = 7'b1111111;
      4'd9:    seg7 = 7'b1111011;
      default: seg7 = 7'b0000000;
    endcase
  endfunction

  assign rwrap = (rcnt == RW'(REFRESH_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= UNITS;
      rcnt  <= '0;
    end else begin
      state <= state_nxt;
      rcnt  <= rwrap ? '0 : rcnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (rwrap) state_nxt = (state == UNITS) ? TENS : UNITS;
  end

`ifdef ZERO_BLINK_EN
  logic blink;

  // Held visible while anything is free so a fresh all-busy episode starts lit.
  always_ff @(posedge clk) begin
    if (rst || !all_busy) blink <= 1'b0;
    else if (state == TENS && state_nxt == UNITS) blink <= ~blink;
  end
`endif

  always_comb begin
    an_d  = 2'b01;
    seg_d = seg7(units);
    if (state == TENS) begin
      an_d  = 2'b10;
      seg_d = (tens == 4'd0) ? 7'b0000000 : seg7(tens);
    end
`ifdef ZERO_BLINK_EN
    if (all_busy && blink) seg_d = 7'b0000000;
`endif
  end

  // Outputs lag the state by one edge so each digit is lit for exactly REFRESH_CYCLES.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg <= 7'b0000000;
      an  <= 2'b00;
    end else begin
      seg <= seg_d;
      an  <= an_d;
    end
  end
endmodule

// File: tb/tb_free_station_display.sv
// Directed bench: two instances (5 and 12 stations) sharing clock and reset.
module tb_free_station_display;
  localparam int D = 4;
  localparam int R = 6;
  localparam int L = 3 + D;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  comps5;
  logic [11:0] comps12;
  logic [6:0]  free5, seg5, free12, seg12;
  logic [1:0]  an5, an12;
  logic        busy5, chg5, busy12, chg12;

  int checks = 0;
  int failures = 0;
  int since_rel = 0;

  free_station_display #(.N_COMPS(5), .DEBOUNCE_CYCLES(D), .REFRESH_CYCLES(R)) dut5 (
    .clk(clk), .rst(rst), .comps(comps5), .free_cnt(free5), .seg(seg5), .an(an5),
    .all_busy(busy5), .cnt_changed(chg5));

  free_station_display #(.N_COMPS(12), .DEBOUNCE_CYCLES(D), .REFRESH_CYCLES(R)) dut12 (
    .clk(clk), .rst(rst), .comps(comps12), .free_cnt(free12), .seg(seg12), .an(an12),
    .all_busy(busy12), .cnt_changed(chg12));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    since_rel++;
  endtask

  function automatic logic [1:0] exp_an();
    return ((((since_rel - 1) / R) % 2) == 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic test_reset();
    logic [1:0] ea;
    logic [6:0] es;
    rst = 1'b1; comps5 = '0; comps12 = '0;
    repeat (3) tick();
    checks++; if (free5 !== 7'd5) begin failures++; $display("FAIL reset_free got=%0d exp=5", free5); end
    checks++; if (seg5 !== 7'b0) begin failures++; $display("FAIL reset_seg got=%b exp=0000000", seg5); end
    checks++; if (an5 !== 2'b00) begin failures++; $display("FAIL reset_an got=%b exp=00", an5); end
    checks++; if (busy5 !== 1'b0 || chg5 !== 1'b0) begin failures++; $display("FAIL reset_flags busy=%b chg=%b exp=0,0", busy5, chg5); end
    checks++; if (free12 !== 7'd12) begin failures++; $display("FAIL reset_free12 got=%0d exp=12", free12); end
    rst = 1'b0;
    since_rel = 0;
    for (int k = 1; k <= 2 * R; k++) begin
      tick();
      ea = exp_an();
      es = (ea == 2'b01) ? 7'b1011011 : 7'b0000000;
      checks++; if (an5 !== ea) begin failures++; $display("FAIL idle_an k=%0d got=%b exp=%b", k, an5, ea); end
      checks++; if (seg5 !== es) begin failures++; $display("FAIL idle_seg k=%0d got=%b exp=%b", k, seg5, es); end
      checks++; if (free5 !== 7'd5 || chg5 !== 1'b0) begin failures++; $display("FAIL idle_free k=%0d got=%0d chg=%b exp=5,0", k, free5, chg5); end
    end
  endtask

  task automatic test_change();
    logic [1:0] ea;
    logic [6:0] es;
    comps5 = 5'b00111;
    for (int k = 1; k <= L + 1; k++) begin
      tick();
      checks++; if (free5 !== ((k >= L) ? 7'd2 : 7'd5)) begin failures++; $display("FAIL change_free k=%0d got=%0d exp=%0d", k, free5, (k >= L) ? 2 : 5); end
      checks++; if (chg5 !== (k == L)) begin failures++; $display("FAIL change_pulse k=%0d got=%b exp=%b", k, chg5, k == L); end
    end
    for (int k = 1; k <= 2 * R; k++) begin
      tick();
      ea = exp_an();
      es = (ea == 2'b01) ? 7'b1101101 : 7'b0000000;
      checks++; if (an5 !== ea || seg5 !== es) begin failures++; $display("FAIL change_seg k=%0d an=%b seg=%b exp=%b,%b", k, an5, seg5, ea, es); end
    end
  endtask

  task automatic test_glitch();
    comps5 = 5'b00110;
    tick(); tick();
    comps5 = 5'b00111;
    for (int k = 1; k <= 12; k++) begin
      tick();
      checks++; if (free5 !== 7'd2 || chg5 !== 1'b0) begin failures++; $display("FAIL glitch k=%0d free=%0d chg=%b exp=2,0", k, free5, chg5); end
    end
  endtask

  task automatic test_n12();
    logic [1:0] ea;
    logic [6:0] es;
    for (int k = 1; k <= 2 * R; k++) begin
      tick();
      ea = exp_an();
      es = (ea == 2'b01) ? 7'b1101101 : 7'b0110000;
      checks++; if (free12 !== 7'd12 || an12 !== ea || seg12 !== es) begin failures++; $display("FAIL n12_idle k=%0d free=%0d an=%b seg=%b exp=12,%b,%b", k, free12, an12, seg12, ea, es); end
    end
    comps12 = 12'hFFF;
    for (int k = 1; k <= L; k++) begin
      tick();
      if (k == L - 1) begin
        checks++; if (free12 !== 7'd12 || busy12 !== 1'b0) begin failures++; $display("FAIL n12_early free=%0d busy=%b exp=12,0", free12, busy12); end
      end
      if (k == L) begin
        checks++; if (free12 !== 7'd0 || busy12 !== 1'b1 || chg12 !== 1'b1) begin failures++; $display("FAIL n12_busy free=%0d busy=%b chg=%b exp=0,1,1", free12, busy12, chg12); end
      end
    end
    tick(); tick();
  endtask

  task automatic test_zero_display();
    logic [1:0] ea;
    logic [6:0] es;
`ifdef ZERO_BLINK_EN
    logic [6:0] samp [0:7];
    int ns = 0;
    for (int k = 1; k <= 8 * R; k++) begin
      tick();
      ea = exp_an();
      if (ea == 2'b10) begin
        checks++; if (seg12 !== 7'b0) begin failures++; $display("FAIL blink_tens k=%0d got=%b exp=0000000", k, seg12); end
      end else if (((since_rel - 1) % R) == R / 2 && ns < 8) begin
        samp[ns] = seg12;
        ns++;
      end
    end
    checks++; if (ns < 4) begin failures++; $display("FAIL blink_samples got=%0d exp>=4", ns); end
    for (int i = 0; i < ns; i++) begin
      checks++; if (samp[i] !== 7'b1111110 && samp[i] !== 7'b0) begin failures++; $display("FAIL blink_val i=%0d got=%b exp=1111110|0000000", i, samp[i]); end
      if (i > 0) begin
        checks++; if (samp[i] === samp[i-1]) begin failures++; $display("FAIL blink_alt i=%0d got=%b prev=%b exp=different", i, samp[i], samp[i-1]); end
      end
    end
`else
    for (int k = 1; k <= 4 * R; k++) begin
      tick();
      ea = exp_an();
      es = (ea == 2'b01) ? 7'b1111110 : 7'b0000000;
      checks++; if (seg12 !== es) begin failures++; $display("FAIL zero_steady k=%0d got=%b exp=%b", k, seg12, es); end
    end
`endif
    comps12 = 12'hFFE;
    for (int k = 1; k <= L; k++) tick();
    checks++; if (free12 !== 7'd1 || busy12 !== 1'b0 || chg12 !== 1'b1) begin failures++; $display("FAIL unbusy free=%0d busy=%b chg=%b exp=1,0,1", free12, busy12, chg12); end
    tick(); tick();
    for (int k = 1; k <= 2 * R; k++) begin
      tick();
      ea = exp_an();
      es = (ea == 2'b01) ? 7'b0110000 : 7'b0000000;
      checks++; if (seg12 !== es) begin failures++; $display("FAIL unbusy_seg k=%0d got=%b exp=%b", k, seg12, es); end
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] ea;
    logic [6:0] es;
    comps5 = 5'b00011;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    checks++; if (free5 !== 7'd5 || seg5 !== 7'b0 || an5 !== 2'b00 || busy5 !== 1'b0 || chg5 !== 1'b0) begin
      failures++; $display("FAIL midrst5 free=%0d seg=%b an=%b busy=%b chg=%b exp=5,0000000,00,0,0", free5, seg5, an5, busy5, chg5); end
    checks++; if (free12 !== 7'd12 || seg12 !== 7'b0 || an12 !== 2'b00 || busy12 !== 1'b0 || chg12 !== 1'b0) begin
      failures++; $display("FAIL midrst12 free=%0d seg=%b an=%b busy=%b chg=%b exp=12,0000000,00,0,0", free12, seg12, an12, busy12, chg12); end
    tick();
    rst = 1'b0;
    since_rel = 0;
    for (int k = 1; k <= 2 * R; k++) begin
      tick();
      ea = exp_an();
      es = (ea == 2'b10) ? 7'b0000000 : ((k >= L + 2) ? 7'b1111001 : 7'b1011011);
      checks++; if (an5 !== ea || an12 !== ea) begin failures++; $display("FAIL postrst_an k=%0d got=%b,%b exp=%b", k, an5, an12, ea); end
      checks++; if (seg5 !== es) begin failures++; $display("FAIL postrst_seg k=%0d got=%b exp=%b", k, seg5, es); end
      checks++; if (free5 !== ((k >= L) ? 7'd3 : 7'd5) || chg5 !== (k == L)) begin failures++; $display("FAIL postrst_free k=%0d got=%0d chg=%b exp=%0d,%b", k, free5, chg5, (k >= L) ? 3 : 5, k == L); end
    end
  endtask

  initial begin
    test_reset();
    test_change();
    test_glitch();
    test_n12();
    test_zero_display();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
